uart_alici_param: RTL and testbench

UART_ALICI_PARAM -- requirements
Module: uart_alici_param

---
 rtl/uart_alici_param_pkg.sv | 31 +++
 rtl/uart_alici_fifo.sv | 63 ++++++
 rtl/uart_alici_param.sv | 219 +++++++++++++++++++++
 tb/tb_uart_alici_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_alici_param_pkg.sv
// Shared constants for the parameterised UART receiver: FSM state codes,
// parity mode codes, the minimum bit divisor and small bit-level helpers.
package uart_alici_param_pkg;

    typedef enum logic [2:0] {
        BOSTA = 3'd0,
        START = 3'd1,
        VERI  = 3'd2,
        ESLIK = 3'd3,
        DUR   = 3'd4
    } durum_t;

    typedef enum logic [1:0] {
        ESLIK_YOK   = 2'd0,
        ESLIK_CIFT  = 2'd1,
        ESLIK_TEK   = 2'd2,
        ESLIK_YOK_3 = 2'd3
    } eslik_t;

    localparam int unsigned MIN_BOLEN = 16;

    function automatic logic cogunluk(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Expected parity bit over the data; unused upper bits must be zero.
    function automatic logic eslik_hesap(input logic [7:0] veri, input logic tek);
        return tek ? ~(^veri) : (^veri);
    endfunction

endpackage

// File: rtl/uart_alici_fifo.sv
// Receive FIFO: power-of-two depth, wrap-bit full/empty, drop-on-full with a
// one-cycle overflow pulse. Output reads as zero while empty.
module uart_alici_fifo #(
    parameter int GENISLIK = 11,
    parameter int DERINLIK = 4
) (
    input  logic                clk_g,
    input  logic                rst_g,
    input  logic                it,
    input  logic                cek,
    input  logic [GENISLIK-1:0] giris,
    output logic [GENISLIK-1:0] cikis,
    output logic                gecerli,
    output logic                tasma
);
    localparam int AW = $clog2(DERINLIK);

    logic [GENISLIK-1:0] bellek_r [DERINLIK];
    logic [AW:0]         yaz_r;
    logic [AW:0]         oku_r;
    logic                tasma_r;
    logic                bos_s;
    logic                dolu_s;
    logic                cek_s;
    logic                yaz_s;

    // Occupancy flags and accepted push/pop decisions.
    always_comb begin
        bos_s  = (yaz_r == oku_r);
        dolu_s = (yaz_r[AW] != oku_r[AW]) && (yaz_r[AW-1:0] == oku_r[AW-1:0]);
        cek_s  = cek && !bos_s;
        yaz_s  = it && (!dolu_s || cek_s);
    end

    // Frame storage; contents are never visible while empty, so no reset.
    always_ff @(posedge clk_g) begin
        if (yaz_s) begin
            bellek_r[yaz_r[AW-1:0]] <= giris;
        end
    end

    // Pointers and overflow pulse.
    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            yaz_r   <= '0;
            oku_r   <= '0;
            tasma_r <= 1'b0;
        end else begin
            if (yaz_s) begin
                yaz_r <= yaz_r + (AW+1)'(1);
            end
            if (cek_s) begin
                oku_r <= oku_r + (AW+1)'(1);
            end
            tasma_r <= it && dolu_s && !cek_s;
        end
    end

    assign cikis   = bos_s ? '0 : bellek_r[oku_r[AW-1:0]];
    assign gecerli = !bos_s;
    assign tasma   = tasma_r;

endmodule

// File: rtl/uart_alici_param.sv
// Parameterised UART receiver with 3-sample majority voting and a frame FIFO.
// Optional parity support is compiled in with `define UART_ALICI_ESLIK_EN.
module uart_alici_param
    import uart_alici_param_pkg::*;
#(
    parameter int VERI_BIT       = 8,
    parameter int FIFO_DERINLIK  = 4,
    parameter int BOLEN_GENISLIK = 16
) (
    input  logic                      clk_g,
    input  logic                      rst_g,
    input  logic                      RX,
    input  logic [BOLEN_GENISLIK-1:0] baud_bolen,
    input  logic [1:0]                eslik_mod,
    input  logic                      iki_dur,
    output logic [VERI_BIT-1:0]       al_veri,
    output logic                      al_gecerli,
    input  logic                      al_hazir,
    output logic                      cerceve_hata,
    output logic                      eslik_hata,
    output logic                      kirilma,
    output logic                      tasma
);
    localparam int GEN = VERI_BIT + 3;
    localparam logic [BOLEN_GENISLIK-1:0] MIN_D = BOLEN_GENISLIK'(MIN_BOLEN);

    logic                      sync1_r, sync2_r, rx_s;
    durum_t                    durum_r, durum_s;
    logic [BOLEN_GENISLIK-1:0] bolen_r, bolen_s, sayac_r;
    logic [BOLEN_GENISLIK-1:0] adim_s, o7_s, o8_s, o9_s;
    logic [1:0]                ornek_r;
    logic                      bit_r, maj_s, bit_son_s, son_dur_s, veri_son_s;
    logic [3:0]                bit_say_r;
    logic [VERI_BIT-1:0]       veri_r;
    logic                      stop_say_r, iki_dur_r, cerceve_r, sifir_r, bekle_r;
    logic                      eslik_var_s, eslik_bit_s, itme_s;
    logic                      cerceve_son_s, kirilma_son_s;
    logic [GEN-1:0]            yaz_veri_s, fifo_cikis_s;

`ifdef UART_ALICI_ESLIK_EN
    logic [1:0] mod_r;
    logic       eslik_r;
    assign eslik_var_s = (mod_r == ESLIK_CIFT) || (mod_r == ESLIK_TEK);
    assign eslik_bit_s = eslik_r;
`else
    logic unused_eslik_mod_s;
    assign unused_eslik_mod_s = ^eslik_mod;
    assign eslik_var_s        = 1'b0;
    assign eslik_bit_s        = 1'b0;
`endif

    // Two-flop synchroniser on the serial line, idling high.
    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= RX;
            sync2_r <= sync1_r;
        end
    end
    assign rx_s = sync2_r;

    // Bit timing: divisor clamp, sample points and bit-end detection.
    always_comb begin
        bolen_s    = (baud_bolen < MIN_D) ? MIN_D : baud_bolen;
        adim_s     = bolen_r >> 4;
        o7_s       = adim_s * BOLEN_GENISLIK'(7);
        o8_s       = adim_s * BOLEN_GENISLIK'(8);
        o9_s       = adim_s * BOLEN_GENISLIK'(9);
        bit_son_s  = (sayac_r == bolen_r - BOLEN_GENISLIK'(1));
        maj_s      = cogunluk(ornek_r[0], ornek_r[1], rx_s);
        son_dur_s  = !iki_dur_r || stop_say_r;
        veri_son_s = (bit_say_r == 4'(VERI_BIT - 1));
    end

    // FSM state register.
    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            durum_r <= BOSTA;
        end else begin
            durum_r <= durum_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        durum_s = durum_r;
        case (durum_r)
            BOSTA: begin
                if (!rx_s && !bekle_r) durum_s = START;
                else                   durum_s = BOSTA;
            end
            START: begin
                if (bit_son_s) durum_s = bit_r ? BOSTA : VERI;
                else           durum_s = START;
            end
            VERI: begin
                if (bit_son_s && veri_son_s) durum_s = eslik_var_s ? ESLIK : DUR;
                else                         durum_s = VERI;
            end
            ESLIK: begin
                if (bit_son_s) durum_s = DUR;
                else           durum_s = ESLIK;
            end
            DUR: begin
                if (itme_s) durum_s = BOSTA;
                else        durum_s = DUR;
            end
            default: durum_s = BOSTA;
        endcase
    end

    // FSM outputs: push strobe mid-way through the last stop bit and the frame word.
    always_comb begin
        itme_s        = (durum_r == DUR) && son_dur_s && (sayac_r == o9_s);
        cerceve_son_s = cerceve_r | ~maj_s;
        kirilma_son_s = stop_say_r ? sifir_r : (sifir_r & ~maj_s);
        yaz_veri_s    = {kirilma_son_s, eslik_bit_s, cerceve_son_s, veri_r};
    end

    // Datapath: bit counter, majority samples, shift register and error tracking.
    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            sayac_r    <= '0;
            bolen_r    <= MIN_D;
            ornek_r    <= 2'b11;
            bit_r      <= 1'b1;
            bit_say_r  <= 4'd0;
            veri_r     <= '0;
            stop_say_r <= 1'b0;
            iki_dur_r  <= 1'b0;
            cerceve_r  <= 1'b0;
            sifir_r    <= 1'b1;
            bekle_r    <= 1'b0;
`ifdef UART_ALICI_ESLIK_EN
            mod_r      <= 2'd0;
            eslik_r    <= 1'b0;
`endif
        end else if (durum_r == BOSTA) begin
            sayac_r    <= '0;
            bolen_r    <= bolen_s;
            iki_dur_r  <= iki_dur;
            ornek_r    <= 2'b11;
            bit_say_r  <= 4'd0;
            stop_say_r <= 1'b0;
            cerceve_r  <= 1'b0;
            sifir_r    <= 1'b1;
`ifdef UART_ALICI_ESLIK_EN
            mod_r      <= eslik_mod;
            eslik_r    <= 1'b0;
`endif
            // After a frame ending in a low stop bit, wait for idle before re-arming.
            if (rx_s) begin
                bekle_r <= 1'b0;
            end
        end else begin
            sayac_r <= bit_son_s ? '0 : sayac_r + BOLEN_GENISLIK'(1);
            if (sayac_r == o7_s) begin
                ornek_r[0] <= rx_s;
            end
            if (sayac_r == o8_s) begin
                ornek_r[1] <= rx_s;
            end
            if (sayac_r == o9_s) begin
                bit_r <= maj_s;
                case (durum_r)
                    VERI: begin
                        veri_r  <= {maj_s, veri_r[VERI_BIT-1:1]};
                        sifir_r <= sifir_r & ~maj_s;
                    end
                    ESLIK: begin
                        sifir_r <= sifir_r & ~maj_s;
`ifdef UART_ALICI_ESLIK_EN
                        eslik_r <= maj_s != eslik_hesap(8'(veri_r), mod_r == ESLIK_TEK);
`endif
                    end
                    DUR: begin
                        if (!stop_say_r) begin
                            cerceve_r <= ~maj_s;
                            sifir_r   <= sifir_r & ~maj_s;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (bit_son_s && durum_r == VERI) begin
                bit_say_r <= bit_say_r + 4'd1;
            end
            if (bit_son_s && durum_r == DUR) begin
                stop_say_r <= 1'b1;
            end
            if (itme_s) begin
                bekle_r <= cerceve_son_s;
            end
        end
    end

    uart_alici_fifo #(
        .GENISLIK (GEN),
        .DERINLIK (FIFO_DERINLIK)
    ) u_fifo (
        .clk_g   (clk_g),
        .rst_g   (rst_g),
        .it      (itme_s),
        .cek     (al_hazir),
        .giris   (yaz_veri_s),
        .cikis   (fifo_cikis_s),
        .gecerli (al_gecerli),
        .tasma   (tasma)
    );

    assign al_veri      = fifo_cikis_s[VERI_BIT-1:0];
    assign cerceve_hata = fifo_cikis_s[VERI_BIT];
    assign eslik_hata   = fifo_cikis_s[VERI_BIT+1];
    assign kirilma      = fifo_cikis_s[VERI_BIT+2];

endmodule

// File: tb/tb_uart_alici_param.sv
// Randomised scoreboard bench for uart_alici_param: frames are serialised from a
// behavioural model, expected words queued, and a monitor checks every pop.
module tb_uart_alici_param;
    localparam int VB  = 8;
    localparam int DEP = 4;
    localparam int BW  = 16;

    logic          clk_g = 1'b0;
    logic          rst_g, RX, iki_dur, al_hazir;
    logic [BW-1:0] baud_bolen;
    logic [1:0]    eslik_mod;
    logic [VB-1:0] al_veri;
    logic          al_gecerli, cerceve_hata, eslik_hata, kirilma, tasma;

    int vektor = 0;
    int hata = 0;
    int tasma_gorulen = 0;
    int tasma_beklenen = 0;
    logic [VB+2:0] beklenen_q[$];
    logic [VB+2:0] gelen;

    uart_alici_param #(
        .VERI_BIT       (VB),
        .FIFO_DERINLIK  (DEP),
        .BOLEN_GENISLIK (BW)
    ) dut (
        .clk_g        (clk_g),
        .rst_g        (rst_g),
        .RX           (RX),
        .baud_bolen   (baud_bolen),
        .eslik_mod    (eslik_mod),
        .iki_dur      (iki_dur),
        .al_veri      (al_veri),
        .al_gecerli   (al_gecerli),
        .al_hazir     (al_hazir),
        .cerceve_hata (cerceve_hata),
        .eslik_hata   (eslik_hata),
        .kirilma      (kirilma),
        .tasma        (tasma)
    );

    always #5 clk_g = ~clk_g;

    // Monitor: every accepted pop is checked against the scoreboard head.
    always @(negedge clk_g) begin
        if (!rst_g) begin
            if (tasma) tasma_gorulen++;
            if (al_gecerli && al_hazir) begin
                vektor++;
                if (beklenen_q.size() == 0) begin
                    hata++;
                    $display("FAIL frame_unexpected got={brk,par,frm,data}=%h", {kirilma, eslik_hata, cerceve_hata, al_veri});
                end else begin
                    gelen = beklenen_q.pop_front();
                    if ({kirilma, eslik_hata, cerceve_hata, al_veri} !== gelen) begin
                        hata++;
                        $display("FAIL frame_data got=%h expected=%h", {kirilma, eslik_hata, cerceve_hata, al_veri}, gelen);
                    end
                end
            end
        end
    end

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        vektor++;
        if (gercek !== beklenen) begin
            hata++;
            $display("FAIL %s got=%0h expected=%0h", ad, gercek, beklenen);
        end
    endtask

    function automatic int bolen_d(input logic [BW-1:0] b);
        return (b < 16) ? 16 : int'(b);
    endfunction

    function automatic logic eslik_etkin(input logic [1:0] mod);
`ifdef UART_ALICI_ESLIK_EN
        return (mod == 2'd1) || (mod == 2'd2);
`else
        return 1'b0;
`endif
    endfunction

    // Parity bit a correct transmitter would send: even mode makes the total count of ones even.
    function automatic logic eslik_biti(input logic [7:0] d, input logic [1:0] mod);
        int birler;
        birler = $countones(d);
        return (mod == 2'd1) ? logic'(birler % 2) : logic'(1 - (birler % 2));
    endfunction

    task automatic bit_gonder(input logic v, input int n);
        RX = v;
        repeat (n) @(posedge clk_g);
        #1;
    endtask

    task automatic cerceve_gonder(input logic [7:0] d, input logic [1:0] mod, input logic iki,
                                  input logic bozuk_par, input logic dur0, input logic pop_darbe);
        int dd, o9;
        logic pe, pb, son;
        dd = bolen_d(baud_bolen);
        o9 = (dd / 16) * 9;
        eslik_mod = mod;
        iki_dur = iki;
        pe = eslik_etkin(mod);
        pb = eslik_biti(d, mod) ^ bozuk_par;
        if (!al_hazir && !pop_darbe && beklenen_q.size() == DEP)
            tasma_beklenen++;
        else
            beklenen_q.push_back({(d == 8'h00) && (!pe || !pb) && dur0, pe && bozuk_par, dur0, d});
        bit_gonder(1'b0, dd);
        for (int i = 0; i < VB; i++) bit_gonder(d[i], dd);
        if (pe) bit_gonder(pb, dd);
        if (iki) begin
            bit_gonder(!dur0, dd);
            son = 1'b1;
        end else begin
            son = !dur0;
        end
        if (pop_darbe) begin
            RX = son;
            repeat (o9 + 3) @(posedge clk_g);
            #1 al_hazir = 1'b1;
            @(posedge clk_g);
            #1 al_hazir = 1'b0;
            repeat (dd - o9 - 4) @(posedge clk_g);
            #1;
        end else begin
            bit_gonder(son, dd);
        end
        bit_gonder(1'b1, 2);
    endtask

    task automatic bos_bekle(input string ad, input int sinir);
        int n;
        n = 0;
        while (beklenen_q.size() != 0 && n < sinir) begin
            @(posedge clk_g);
            n++;
        end
        #1;
        kontrol(ad, beklenen_q.size(), 0);
    endtask

    initial begin
        rst_g = 1'b1; RX = 1'b1; baud_bolen = 16'd16; eslik_mod = 2'd0; iki_dur = 1'b0; al_hazir = 1'b1;
        repeat (3) @(posedge clk_g);
        #1;
        kontrol("reset_gecerli", al_gecerli, 0);
        kontrol("reset_veri", al_veri, 0);
        kontrol("reset_bayrak", {kirilma, eslik_hata, cerceve_hata, tasma}, 0);
        rst_g = 1'b0;
        bit_gonder(1'b1, 4);

        cerceve_gonder(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bos_bekle("a5_8n1", 100);
        // Even parity on 0x07 needs a 1; a 0 is sent instead.
        cerceve_gonder(8'h07, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        bos_bekle("eslik", 100);
        cerceve_gonder(8'h3C, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        bos_bekle("cerceve", 100);

        beklenen_q.push_back({1'b1, 1'b0, 1'b1, 8'h00});
        bit_gonder(1'b0, 12 * 16);
        bit_gonder(1'b1, 3 * 16);
        bos_bekle("kirilma", 200);

        bit_gonder(1'b0, 4);
        bit_gonder(1'b1, 3 * 16);
        kontrol("yanlis_start", al_gecerli, 0);

        al_hazir = 1'b0;
        for (int i = 0; i < 5; i++) cerceve_gonder(8'(i * 37 + 3), 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bit_gonder(1'b1, 4);
        kontrol("tasma_bir", tasma_gorulen, tasma_beklenen);
        kontrol("dolu_gecerli", al_gecerli, 1);
        kontrol("dolu_bas", {kirilma, eslik_hata, cerceve_hata, al_veri}, beklenen_q[0]);
        cerceve_gonder(8'hC3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        kontrol("pop_push_tasma", tasma_gorulen, tasma_beklenen);
        al_hazir = 1'b1;
        bos_bekle("dolu_bosalt", 100);

        al_hazir = 1'b0;
        cerceve_gonder(8'h96, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bit_gonder(1'b0, 16);
        bit_gonder(1'b1, 16);
        bit_gonder(1'b0, 16);
        bit_gonder(1'b1, 8);
        rst_g = 1'b1;
        RX = 1'b1;
        @(posedge clk_g);
        #1;
        beklenen_q.delete();
        kontrol("rst_gecerli", al_gecerli, 0);
        kontrol("rst_veri", al_veri, 0);
        kontrol("rst_bayrak", {kirilma, eslik_hata, cerceve_hata, tasma}, 0);
        repeat (3) @(posedge clk_g);
        #1 rst_g = 1'b0;
        bit_gonder(1'b1, 4);
        kontrol("rst_sonra_gecerli", al_gecerli, 0);
        al_hazir = 1'b1;
        cerceve_gonder(8'h55, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bos_bekle("rst_55", 100);

        for (int i = 0; i < 16; i++) begin
            baud_bolen = 16'($urandom_range(4, 40));
            cerceve_gonder(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 1'b0);
            bit_gonder(1'b1, $urandom_range(1, 20));
        end
        bos_bekle("rastgele", 200);
        kontrol("tasma_toplam", tasma_gorulen, tasma_beklenen);

        $display("== %0d vectors applied, %0d miscompares ==", vektor, hata);
        $finish;
    end

endmodule
